// File: rtl/core_ctrl_fsm.sv
// Multicycle control sequencer: fetch/load/store/exec sequencing with bus-error traps,
// wait timeouts and EBREAK halt. Define PERF_CNT_EN to build the cycle/instret counters.
module core_ctrl_fsm #(
    parameter int TYPE_W         = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [TYPE_W-1:0] inst_type,
    input  logic              ifu_respValid,
    input  logic              ifu_respErr,
    input  logic              lsu_respValid,
    input  logic              lsu_respErr,
    output logic              ifu_reqValid,
    output logic              lsu_reqValid,
    output logic              lsu_wen,
    output logic              pc_wen,
    output logic              reg_wen,
    output logic              finished,
    output logic              halted,
    output logic              trap,
    output logic [2:0]        trap_cause,
    output logic [CNT_W-1:0]  perf_cycles,
    output logic [CNT_W-1:0]  perf_instret
);
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_START, S_FETCH, S_LOAD, S_STORE, S_EXEC, S_HALT, S_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic              ifu_inflight_q, ifu_inflight_d;
    logic              lsu_inflight_q, lsu_inflight_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              finished_q, finished_d;
    logic [2:0]        cause_q, cause_d;
    logic              ifu_acc, lsu_acc, timeout_hit;

    assign ifu_acc     = ifu_respValid & ifu_inflight_q;
    assign lsu_acc     = lsu_respValid & lsu_inflight_q;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        finished_d   = 1'b0;
        ifu_reqValid = 1'b0;
        lsu_reqValid = 1'b0;
        lsu_wen      = 1'b0;
        pc_wen       = 1'b0;
        reg_wen      = 1'b0;
        case (state_q)
            S_START: begin
                ifu_reqValid = 1'b1;
                state_d      = S_FETCH;
            end
            S_FETCH: begin
                if (ifu_acc) begin
                    if (ifu_respErr) begin
                        state_d = S_TRAP;
                        cause_d = 3'd1;
                    end else begin
                        pc_wen = 1'b1;
                        case (inst_type)
                            TYPE_W'(1), TYPE_W'(2), TYPE_W'(3): begin
                                lsu_reqValid = 1'b1;
                                state_d      = S_LOAD;
                            end
                            TYPE_W'(4): begin
                                lsu_reqValid = 1'b1;
                                lsu_wen      = 1'b1;
                                state_d      = S_STORE;
                            end
                            TYPE_W'(15): begin
                                finished_d = 1'b1;
                                state_d    = S_HALT;
                            end
                            default: begin
                                reg_wen = 1'b1;
                                state_d = S_EXEC;
                            end
                        endcase
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 3'd4;
                end
            end
            S_LOAD: begin
                if (lsu_acc) begin
                    if (lsu_respErr) begin
                        state_d = S_TRAP;
                        cause_d = 3'd2;
                    end else begin
                        reg_wen = 1'b1;
                        state_d = S_EXEC;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 3'd4;
                end
            end
            S_STORE: begin
                if (lsu_acc) begin
                    if (lsu_respErr) begin
                        state_d = S_TRAP;
                        cause_d = 3'd3;
                    end else begin
                        ifu_reqValid = 1'b1;
                        finished_d   = 1'b1;
                        state_d      = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 3'd4;
                end
            end
            S_EXEC: begin
                ifu_reqValid = 1'b1;
                finished_d   = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT, S_TRAP: ;
            default: begin
                ifu_reqValid = 1'b1;
                state_d      = S_FETCH;
            end
        endcase

        // A request issued this cycle takes priority over a stale accept.
        ifu_inflight_d = ifu_reqValid ? 1'b1 : (ifu_acc ? 1'b0 : ifu_inflight_q);
        lsu_inflight_d = lsu_reqValid ? 1'b1 : (lsu_acc ? 1'b0 : lsu_inflight_q);

        wait_cnt_d = wait_cnt_q;
        if (ifu_reqValid || lsu_reqValid)
            wait_cnt_d = '0;
        else if ((state_q == S_FETCH && !ifu_acc) ||
                 ((state_q == S_LOAD || state_q == S_STORE) && !lsu_acc))
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_START;
            ifu_inflight_q <= 1'b0;
            lsu_inflight_q <= 1'b0;
            wait_cnt_q     <= '0;
            finished_q     <= 1'b0;
            cause_q        <= 3'd0;
        end else begin
            state_q        <= state_d;
            ifu_inflight_q <= ifu_inflight_d;
            lsu_inflight_q <= lsu_inflight_d;
            wait_cnt_q     <= wait_cnt_d;
            finished_q     <= finished_d;
            cause_q        <= cause_d;
        end
    end

    assign finished   = finished_q;
    assign halted     = (state_q == S_HALT);
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycles_q, cycles_d, instret_q, instret_d;

    always_comb begin
        cycles_d  = cycles_q;
        instret_d = instret_q;
        if (state_q != S_HALT && state_q != S_TRAP)
            cycles_d = cycles_q + CNT_W'(1);
        if (finished_q)
            instret_d = instret_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            cycles_q  <= cycles_d;
            instret_q <= instret_d;
        end
    end

    assign perf_cycles  = cycles_q;
    assign perf_instret = instret_q;
`else
    assign perf_cycles  = '0;
    assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Table-driven bench for core_ctrl_fsm (TIMEOUT_CYCLES=4); one row per clock cycle,
// plus hand-written perf and store-timeout sequences.
module tb_core_ctrl_fsm;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  inst_type = '0;
    logic        ifu_respValid = 1'b0, ifu_respErr = 1'b0;
    logic        lsu_respValid = 1'b0, lsu_respErr = 1'b0;
    logic        ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen;
    logic        finished, halted, trap;
    logic [2:0]  trap_cause;
    logic [31:0] perf_cycles, perf_instret;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    core_ctrl_fsm #(.TYPE_W(4), .TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .inst_type(inst_type),
        .ifu_respValid(ifu_respValid), .ifu_respErr(ifu_respErr),
        .lsu_respValid(lsu_respValid), .lsu_respErr(lsu_respErr),
        .ifu_reqValid(ifu_reqValid), .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen),
        .pc_wen(pc_wen), .reg_wen(reg_wen), .finished(finished), .halted(halted),
        .trap(trap), .trap_cause(trap_cause),
        .perf_cycles(perf_cycles), .perf_instret(perf_instret)
    );

    // exp = {ifu_req, lsu_req, lsu_wen, pc_wen, reg_wen, finished, halted, trap, cause[2:0]}
    typedef struct {
        logic        rst;
        logic        iv, ie;
        logic [3:0]  it;
        logic        lv, le;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic iv, logic ie, logic [3:0] it,
                                logic lv, logic le, logic [7:0] flags, logic [2:0] cause);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ie = ie; v.it = it; v.lv = lv; v.le = le;
        v.exp = {flags, cause};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        ifu_respValid = 1'b0; ifu_respErr = 1'b0; lsu_respValid = 1'b0; lsu_respErr = 1'b0;
        inst_type = '0;
        #1;
        check("reset_regs", {28'd0, finished, halted, trap, 1'b0} | {29'd0, trap_cause}, 32'd0);
        check("reset_perf", perf_cycles | perf_instret, 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [10:0] act;
        ifu_respValid = v.iv; ifu_respErr = v.ie; inst_type = v.it;
        lsu_respValid = v.lv; lsu_respErr = v.le;
        #1;
        act = {ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen,
               finished, halted, trap, trap_cause};
        n_cmp++;
        if (act !== v.exp) begin
            n_fail++;
            $display("FAIL vec%0d outputs: got %b want %b", idx, act, v.exp);
        end
    endtask

    initial begin
        // main flow: ALU, LW, STORE, then LB with LSU error
        tbl.push_back(mk(1,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b0000_0000, 3'd0));
        tbl.push_back(mk(0,1,0,4'd0, 0,0, 8'b0001_1000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,1,0,4'd3, 0,0, 8'b0101_0100, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b0000_0000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 1,0, 8'b0000_1000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,1,0,4'd4, 0,0, 8'b0111_0100, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 1,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,1,0,4'd1, 0,0, 8'b0101_0100, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 1,1, 8'b0000_0000, 3'd0));
        tbl.push_back(mk(0,1,0,4'd0, 0,0, 8'b0000_0001, 3'd2));
        tbl.push_back(mk(0,0,0,4'd0, 1,0, 8'b0000_0001, 3'd2));
        // fetch bus error
        tbl.push_back(mk(1,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,1,1,4'd0, 0,0, 8'b0000_0000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b0000_0001, 3'd1));
        tbl.push_back(mk(0,1,0,4'd0, 0,0, 8'b0000_0001, 3'd1));
        // fetch timeout after 4 waiting cycles
        tbl.push_back(mk(1,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b0000_0000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b0000_0001, 3'd4));
        // response on the 4th waiting cycle wins over timeout
        tbl.push_back(mk(1,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b0000_0000, 3'd0));
        tbl.push_back(mk(0,1,0,4'd0, 0,0, 8'b0001_1000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b0000_0100, 3'd0));
        // reset during FETCH, stray error response right after release
        tbl.push_back(mk(1,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b0000_0000, 3'd0));
        tbl.push_back(mk(1,1,1,4'd15,0,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b0000_0000, 3'd0));
        tbl.push_back(mk(0,1,0,4'd2, 0,0, 8'b0101_0000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 1,0, 8'b0000_1000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        // three ALU instructions then EBREAK
        tbl.push_back(mk(1,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,1,0,4'd0, 0,0, 8'b0001_1000, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,1,0,4'd0, 0,0, 8'b0001_1100, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,1,0,4'd0, 0,0, 8'b0001_1100, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0));
        tbl.push_back(mk(0,1,0,4'd15,0,0, 8'b0001_0100, 3'd0));
        tbl.push_back(mk(0,0,0,4'd0, 0,0, 8'b0000_0110, 3'd0));
        tbl.push_back(mk(0,1,0,4'd0, 0,0, 8'b0000_0010, 3'd0));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            else @(negedge clock);
            apply(tbl[i], i);
        end

        // 8 non-halted cycles since reset release, 4 retire pulses; counters frozen in HALT
        @(negedge clock); #1;
`ifdef PERF_CNT_EN
        check("perf_cycles", perf_cycles, 32'd8);
        check("perf_instret", perf_instret, 32'd4);
`else
        check("perf_cycles", perf_cycles, 32'd0);
        check("perf_instret", perf_instret, 32'd0);
`endif
        check("halted_hold", {31'd0, halted}, 32'd1);

        // store that never gets its LSU response times out
        do_reset();
        apply(mk(0,0,0,4'd0, 0,0, 8'b1000_0000, 3'd0), 100);
        @(negedge clock); apply(mk(0,1,0,4'd4, 0,0, 8'b0111_0000, 3'd0), 101);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock); apply(mk(0,0,0,4'd0, 0,0, 8'b0000_0000, 3'd0), 102 + k);
        end
        @(negedge clock); apply(mk(0,0,0,4'd0, 1,0, 8'b0000_0001, 3'd4), 106);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
